// File: rtl/rom.sv
// Program ROM: 32-bit words in a fixed byte-address window, loadable by writes, read with 1-cycle latency.
// Optional ROM_BUS_ERROR_EN adds a registered bus_error flag for accesses outside the window.
module rom #(
   parameter logic [31:0] ADDR_BASE    = 32'h0800_0000,
   parameter logic [31:0] WINDOW_BYTES = 32'h0010_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_enable,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
`ifdef ROM_BUS_ERROR_EN
   ,
   output logic        bus_error
`endif
);

   localparam int unsigned DEPTH = 32'(WINDOW_BYTES >> 2);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   offset;
   logic          in_range;
   logic [AW-1:0] index;
   logic          wr_en;

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   data_out_q, data_out_d;

   // Offset-based upper check avoids overflow of ADDR_BASE + WINDOW_BYTES near the top of the map.
   assign offset   = address - ADDR_BASE;
   assign in_range = (address >= ADDR_BASE) && (offset < WINDOW_BYTES);
   assign index    = offset[AW+1:2];
   assign wr_en    = write_enable && in_range && !reset;

   // Storage has no reset: contents survive reset and only writes define them.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[index] <= data_in;
      end
   end

   always_comb begin
      data_out_d = data_out_q;
      if (reset) begin
         data_out_d = 32'h0000_0000;
      end else if (!write_enable) begin
         data_out_d = in_range ? mem_q[index] : 32'h0000_0000;
      end
   end

   always_ff @(posedge clock) begin
      data_out_q <= data_out_d;
   end

   assign data_out = data_out_q;

`ifdef ROM_BUS_ERROR_EN
   logic bus_error_q, bus_error_d;

   always_comb begin
      bus_error_d = reset ? 1'b0 : !in_range;
   end

   always_ff @(posedge clock) begin
      bus_error_q <= bus_error_d;
   end

   assign bus_error = bus_error_q;
`endif

endmodule

// File: tb/tb_rom.sv
// Scoreboard bench for rom: a reference model pushes expected read data per access, popped after the edge.
module tb_rom;

   localparam logic [31:0] BASE = 32'h0800_0000;
   localparam logic [31:0] WIN  = 32'h0010_0000;

   logic        clock;
   logic        reset;
   logic        write_enable;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
`ifdef ROM_BUS_ERROR_EN
   logic        bus_error;
`endif

   rom #(.ADDR_BASE(BASE), .WINDOW_BYTES(WIN)) dut (
      .clock       (clock),
      .reset       (reset),
      .write_enable(write_enable),
      .address     (address),
      .data_in     (data_in),
      .data_out    (data_out)
`ifdef ROM_BUS_ERROR_EN
      ,
      .bus_error   (bus_error)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       tag;
      logic [31:0] exp;
      bit          care;
      bit          berr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m [int unsigned];
   logic [31:0] dout_m;
   bit          dout_known;
   int          n_checks;
   int          n_errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < WIN);
   endfunction

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic rst, input string tag);
      exp_t        e;
      exp_t        got;
      bit          ir;
      int unsigned idx;
      ir  = in_win(addr);
      idx = (addr - BASE) >> 2;
      @(negedge clock);
      reset        = rst;
      write_enable = we;
      address      = addr;
      data_in      = din;
      if (rst) begin
         dout_m     = 32'h0;
         dout_known = 1'b1;
      end else if (we) begin
         if (ir) mem_m[idx] = din;
      end else if (!ir) begin
         dout_m     = 32'h0;
         dout_known = 1'b1;
      end else if (mem_m.exists(idx)) begin
         dout_m     = mem_m[idx];
         dout_known = 1'b1;
      end else begin
         dout_known = 1'b0;
      end
      e.tag  = tag;
      e.exp  = dout_m;
      e.care = dout_known;
      e.berr = rst ? 1'b0 : !ir;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         got = exp_q.pop_front();
         if (got.care) check(got.tag, data_out, got.exp);
`ifdef ROM_BUS_ERROR_EN
         check({got.tag, "_berr"}, {31'b0, bus_error}, {31'b0, got.berr});
`endif
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [31:0] addr_pool [10];

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      dout_m       = 32'h0;
      dout_known   = 1'b0;
      reset        = 1'b1;
      write_enable = 1'b0;
      address      = 32'h0;
      data_in      = 32'h0;

      access(1'b0, BASE, 32'h0, 1'b1, "rst0");
      access(1'b0, BASE, 32'h0, 1'b1, "rst1");

      access(1'b1, BASE,           32'h0123_4567, 1'b0, "wr_base_hold");
      access(1'b0, BASE,           32'h1111_1111, 1'b0, "rd_base");
      access(1'b1, 32'h0810_0000,  32'hFEDC_BA90, 1'b0, "wr_oor_hold");
      access(1'b0, 32'h0810_0000,  32'h0,         1'b0, "rd_oor");
      access(1'b1, 32'h080F_FFFF,  32'h89AB_CDEF, 1'b0, "wr_top_unaligned");
      access(1'b0, 32'h080F_FFFC,  32'h0,         1'b0, "rd_top");
      access(1'b0, BASE,           32'h0,         1'b0, "rd_base_intact");
      access(1'b0, BASE,           32'h0,         1'b1, "rst_mid");
      access(1'b0, BASE,           32'h0,         1'b0, "rd_base_after_rst");
      access(1'b1, BASE + 32'd4,   32'hDEAD_BEEF, 1'b1, "rst_wr");
      access(1'b0, BASE + 32'd4,   32'h0,         1'b0, "rd_unwritten");
      check("no_beef", {31'b0, data_out === 32'hDEAD_BEEF}, 32'd0);
      access(1'b1, BASE + 32'd4,   32'h0,         1'b0, "wr_zero");
      access(1'b0, BASE + 32'd4,   32'h0,         1'b0, "rd_zero");
      access(1'b0, 32'h07FF_FFFC,  32'h0,         1'b0, "rd_below");
      access(1'b0, 32'h080F_FFFE,  32'h0,         1'b0, "rd_top_intact");
      access(1'b0, BASE + 32'd2,   32'h0,         1'b0, "rd_base_unaligned");

      addr_pool[0] = BASE;
      addr_pool[1] = BASE + 32'd4;
      addr_pool[2] = BASE + 32'd9;
      addr_pool[3] = 32'h080F_FFFC;
      addr_pool[4] = 32'h080F_FFFF;
      addr_pool[5] = 32'h0810_0000;
      addr_pool[6] = 32'h07FF_FFFC;
      addr_pool[7] = 32'h0000_0000;
      addr_pool[8] = 32'hFFFF_FFFC;
      addr_pool[9] = BASE + 32'h0008_0001;

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         logic        we;
         logic        rst;
         a   = addr_pool[$urandom_range(0, 9)];
         we  = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 19) == 0);
         access(we, a, $urandom, rst, we ? "rnd_wr" : "rnd_rd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
